// File: rtl/microwave_ctrl_if.sv
// Front-panel / driver bundle for the microwave controller: panel inputs in, lamp/magnetron/buzzer and timer status out.
// Pure signal grouping; no storage and no flow control.
interface microwave_ctrl_if #(
    parameter int TIME_W = 8,
    parameter int PWR_W  = 2
);
    logic              door;
    logic              start;
    logic              cancel;
    logic              tick;
    logic              time_load;
    logic [TIME_W-1:0] time_in;
    logic [PWR_W-1:0]  power_in;
    logic              heat;
    logic              light;
    logic              bell;
    logic              busy;
    logic [TIME_W-1:0] remaining;

    modport master (
        output door, start, cancel, tick, time_load, time_in, power_in,
        input  heat, light, bell, busy, remaining
    );

    modport slave (
        input  door, start, cancel, tick, time_load, time_in, power_in,
        output heat, light, bell, busy, remaining
    );
endinterface

// File: rtl/microwave_ctrl.sv
// Microwave oven controller: door interlock, countdown cook timer, PWM power and timed bell.
// One-cycle latency from input sample to state change, Moore outputs; no backpressure, inputs sampled every cycle.
module microwave_ctrl #(
    parameter int TIME_W      = 8,
    parameter int PWR_W       = 2,
    parameter int BELL_TICKS  = 3,
    parameter bit AUTO_RESUME = 1'b1
) (
    input  logic             clk,
    input  logic             nrst,
    microwave_ctrl_if.slave  bus
);
    localparam int P  = (2 ** PWR_W) - 1;
    localparam int BW = (BELL_TICKS > 1) ? $clog2(BELL_TICKS) : 1;
    localparam logic [PWR_W-1:0] PH_LAST   = PWR_W'(P - 1);
    localparam logic [BW-1:0]    BELL_LAST = BW'(BELL_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPEN,
        S_COOK,
        S_PAUSE,
        S_BELL
    } state_t;

    state_t            state, state_n;
    logic [TIME_W-1:0] rem, rem_n;
    logic [PWR_W-1:0]  power_q, power_n;
    logic [PWR_W-1:0]  phase, phase_n;
    logic [BW-1:0]     bell_cnt, bell_n;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state    <= S_IDLE;
            rem      <= '0;
            power_q  <= '0;
            phase    <= '0;
            bell_cnt <= '0;
        end else begin
            state    <= state_n;
            rem      <= rem_n;
            power_q  <= power_n;
            phase    <= phase_n;
            bell_cnt <= bell_n;
        end
    end

    always_comb begin
        state_n = state;
        rem_n   = rem;
        power_n = power_q;
        phase_n = phase;
        bell_n  = bell_cnt;
        case (state)
            S_IDLE: begin
                // The load lands in rem, but start still qualifies on the old value.
                if (bus.time_load) rem_n = bus.time_in;
                if (bus.door) begin
                    state_n = S_OPEN;
                end else if (bus.start && rem != '0) begin
                    state_n = S_COOK;
                    power_n = bus.power_in;
                    phase_n = '0;
                end
            end
            S_OPEN: begin
                if (bus.time_load) rem_n = bus.time_in;
                if (!bus.door) state_n = S_IDLE;
            end
            S_COOK: begin
                phase_n = (phase == PH_LAST) ? '0 : phase + PWR_W'(1);
                if (bus.cancel) begin
                    state_n = S_IDLE;
                    rem_n   = '0;
                end else if (bus.door) begin
                    state_n = S_PAUSE;
                end else if (bus.tick && rem != '0) begin
                    rem_n = rem - TIME_W'(1);
                    if (rem == TIME_W'(1)) begin
                        state_n = S_BELL;
                        bell_n  = '0;
                    end
                end
            end
            S_PAUSE: begin
                if (bus.cancel) begin
                    state_n = bus.door ? S_OPEN : S_IDLE;
                    rem_n   = '0;
                end else if (!bus.door && (AUTO_RESUME || bus.start)) begin
                    state_n = S_COOK;
                    phase_n = '0;
                end
            end
            S_BELL: begin
                if (bus.door) begin
                    state_n = S_OPEN;
                end else if (bus.tick) begin
                    if (bell_cnt == BELL_LAST) state_n = S_IDLE;
                    else                       bell_n  = bell_cnt + BW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Full power (power_q = P) keeps heat on since phase never exceeds P-1.
    assign bus.heat      = (state == S_COOK) && (phase < power_q);
    assign bus.light     = (state == S_OPEN) || (state == S_COOK) || (state == S_PAUSE);
    assign bus.bell      = (state == S_BELL);
    assign bus.busy      = (state == S_COOK) || (state == S_PAUSE);
    assign bus.remaining = rem;
endmodule

// File: tb/tb_microwave_ctrl.sv
// Bench for microwave_ctrl: two instances (auto-resume on and off) share stimulus; expectations queued at drive time.
module tb_microwave_ctrl;
    logic       clk = 1'b0;
    logic       nrst, door, start, cancel, tick, time_load;
    logic [7:0] time_in;
    logic [1:0] power_in;

    always #5 clk = ~clk;

    microwave_ctrl_if #(.TIME_W(8), .PWR_W(2)) if_a ();
    microwave_ctrl_if #(.TIME_W(8), .PWR_W(2)) if_b ();

    assign if_a.door = door;       assign if_b.door = door;
    assign if_a.start = start;     assign if_b.start = start;
    assign if_a.cancel = cancel;   assign if_b.cancel = cancel;
    assign if_a.tick = tick;       assign if_b.tick = tick;
    assign if_a.time_load = time_load; assign if_b.time_load = time_load;
    assign if_a.time_in = time_in; assign if_b.time_in = time_in;
    assign if_a.power_in = power_in; assign if_b.power_in = power_in;

    microwave_ctrl #(.TIME_W(8), .PWR_W(2), .BELL_TICKS(3), .AUTO_RESUME(1'b1)) dut_a (
        .clk(clk), .nrst(nrst), .bus(if_a.slave));
    microwave_ctrl #(.TIME_W(8), .PWR_W(2), .BELL_TICKS(3), .AUTO_RESUME(1'b0)) dut_b (
        .clk(clk), .nrst(nrst), .bus(if_b.slave));

    typedef struct packed {
        logic nrst, door, start, cancel, tick, load;
        logic [7:0] tin;
        logic [1:0] pwr;
    } stim_t;

    // {heat, light, bell, busy, remaining}
    typedef logic [11:0] obs_t;

    typedef struct {
        string name;
        obs_t  a;
        obs_t  b;
    } exp_t;

    exp_t        sb[$];
    logic [23:0] obs_q[$];
    int          errors = 0;
    int          checks = 0;

    function automatic stim_t st(input logic d, input logic s, input logic c, input logic t,
                                 input logic l, input logic [7:0] ti, input logic [1:0] p);
        return '{1'b1, d, s, c, t, l, ti, p};
    endfunction

    function automatic stim_t rst_st();
        return '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0};
    endfunction

    function automatic obs_t ob(input logic h, input logic l, input logic b, input logic bz,
                                input logic [7:0] r);
        return {h, l, b, bz, r};
    endfunction

    task automatic step(input string name, input stim_t s, input obs_t ea, input obs_t eb);
        nrst = s.nrst; door = s.door; start = s.start; cancel = s.cancel;
        tick = s.tick; time_load = s.load; time_in = s.tin; power_in = s.pwr;
        sb.push_back('{name, ea, eb});
        @(posedge clk);
        @(negedge clk);
        obs_q.push_back({if_a.heat, if_a.light, if_a.bell, if_a.busy, if_a.remaining,
                         if_b.heat, if_b.light, if_b.bell, if_b.busy, if_b.remaining});
    endtask

    task automatic step2(input string name, input stim_t s, input obs_t e);
        step(name, s, e, e);
    endtask

    localparam stim_t NOP = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0};
    localparam obs_t  ZERO = 12'h000;

    task automatic test_reset();
        exp_t e; logic [23:0] g;
        step2("reset", rst_st(), ZERO);
        step2("reset_idle", NOP, ZERO);
        while (sb.size() > 0) begin
            e = sb.pop_front(); g = obs_q.pop_front(); checks += 2;
            if (g[23:12] !== e.a) begin errors++; $display("FAIL %s dut_a got %h want %h", e.name, g[23:12], e.a); end
            if (g[11:0]  !== e.b) begin errors++; $display("FAIL %s dut_b got %h want %h", e.name, g[11:0], e.b); end
        end
    endtask

    task automatic test_full_cook();
        exp_t e; logic [23:0] g;
        step2("load3",     st(0,0,0,0,1,8'd3,2'd0), ob(0,0,0,0,3));
        step2("start_p3",  st(0,1,0,0,0,8'd0,2'd3), ob(1,1,0,1,3));
        step2("cook_hold", NOP,                     ob(1,1,0,1,3));
        step2("tick_2",    st(0,0,0,1,0,8'd0,2'd0), ob(1,1,0,1,2));
        step2("tick_1",    st(0,0,0,1,0,8'd0,2'd0), ob(1,1,0,1,1));
        step2("cook_gap",  NOP,                     ob(1,1,0,1,1));
        step2("tick_bell", st(0,0,0,1,0,8'd0,2'd0), ob(0,0,1,0,0));
        step2("bell_t1",   st(0,0,0,1,0,8'd0,2'd0), ob(0,0,1,0,0));
        step2("bell_strt", st(0,1,1,0,1,8'd9,2'd3), ob(0,0,1,0,0));
        step2("bell_t2",   st(0,0,0,1,0,8'd0,2'd0), ob(0,0,1,0,0));
        step2("bell_end",  st(0,0,0,1,0,8'd0,2'd0), ZERO);
        while (sb.size() > 0) begin
            e = sb.pop_front(); g = obs_q.pop_front(); checks += 2;
            if (g[23:12] !== e.a) begin errors++; $display("FAIL %s dut_a got %h want %h", e.name, g[23:12], e.a); end
            if (g[11:0]  !== e.b) begin errors++; $display("FAIL %s dut_b got %h want %h", e.name, g[11:0], e.b); end
        end
    endtask

    task automatic test_pwm();
        exp_t e; logic [23:0] g;
        step2("load5",    st(0,0,0,0,1,8'd5,2'd0), ob(0,0,0,0,5));
        step2("p1_ph0",   st(0,1,0,0,0,8'd0,2'd1), ob(1,1,0,1,5));
        step2("p1_ph1",   NOP,                     ob(0,1,0,1,5));
        step2("p1_ph2",   NOP,                     ob(0,1,0,1,5));
        step2("p1_ph0b",  NOP,                     ob(1,1,0,1,5));
        step2("p1_ph1b",  NOP,                     ob(0,1,0,1,5));
        step2("p1_ph2b",  NOP,                     ob(0,1,0,1,5));
        step2("cancel5",  st(0,0,1,0,0,8'd0,2'd0), ZERO);
        step2("load4",    st(0,0,0,0,1,8'd4,2'd0), ob(0,0,0,0,4));
        step2("p0_start", st(0,1,0,0,0,8'd0,2'd0), ob(0,1,0,1,4));
        for (int i = 0; i < 3; i++) step2("p0_cook", NOP, ob(0,1,0,1,4));
        step2("cancel4",  st(0,0,1,1,0,8'd0,2'd0), ZERO);
        while (sb.size() > 0) begin
            e = sb.pop_front(); g = obs_q.pop_front(); checks += 2;
            if (g[23:12] !== e.a) begin errors++; $display("FAIL %s dut_a got %h want %h", e.name, g[23:12], e.a); end
            if (g[11:0]  !== e.b) begin errors++; $display("FAIL %s dut_b got %h want %h", e.name, g[11:0], e.b); end
        end
    endtask

    task automatic test_pause_resume();
        exp_t e; logic [23:0] g;
        step2("load5",      st(0,0,0,0,1,8'd5,2'd0), ob(0,0,0,0,5));
        step2("start_p1",   st(0,1,0,0,0,8'd0,2'd1), ob(1,1,0,1,5));
        step2("cook_ph1",   NOP,                     ob(0,1,0,1,5));
        step2("door_tick",  st(1,0,0,1,0,8'd0,2'd0), ob(0,1,0,1,5));
        step2("pause_tick", st(1,0,0,1,0,8'd0,2'd0), ob(0,1,0,1,5));
        step("close",       NOP,                     ob(1,1,0,1,5), ob(0,1,0,1,5));
        step("closed",      NOP,                     ob(0,1,0,1,5), ob(0,1,0,1,5));
        step("start_res",   st(0,1,0,0,0,8'd0,2'd0), ob(0,1,0,1,5), ob(1,1,0,1,5));
        step2("reopen",     st(1,0,0,0,0,8'd0,2'd0), ob(0,1,0,1,5));
        step2("cancel_opn", st(1,0,1,0,0,8'd0,2'd0), ob(0,1,0,0,0));
        step2("close_idle", NOP,                     ZERO);
        step2("start_norm", st(0,1,0,0,0,8'd0,2'd3), ZERO);
        while (sb.size() > 0) begin
            e = sb.pop_front(); g = obs_q.pop_front(); checks += 2;
            if (g[23:12] !== e.a) begin errors++; $display("FAIL %s dut_a got %h want %h", e.name, g[23:12], e.a); end
            if (g[11:0]  !== e.b) begin errors++; $display("FAIL %s dut_b got %h want %h", e.name, g[11:0], e.b); end
        end
    endtask

    task automatic test_idle_edges();
        exp_t e; logic [23:0] g;
        step2("start_rem0", st(0,1,0,0,0,8'd0,2'd3), ZERO);
        step2("load_start", st(0,1,0,0,1,8'd2,2'd3), ob(0,0,0,0,2));
        step2("start_rem2", st(0,1,0,0,0,8'd0,2'd3), ob(1,1,0,1,2));
        step2("load_cook",  st(0,0,0,0,1,8'd9,2'd0), ob(1,1,0,1,2));
        step2("cancel",     st(0,0,1,0,0,8'd0,2'd0), ZERO);
        step2("start_door", st(1,1,0,0,0,8'd0,2'd3), ob(0,1,0,0,0));
        step2("load_open",  st(1,0,0,0,1,8'd7,2'd0), ob(0,1,0,0,7));
        step2("close",      NOP,                     ob(0,0,0,0,7));
        step2("strt_door2", st(1,1,0,0,0,8'd0,2'd3), ob(0,1,0,0,7));
        step2("close2",     NOP,                     ob(0,0,0,0,7));
        while (sb.size() > 0) begin
            e = sb.pop_front(); g = obs_q.pop_front(); checks += 2;
            if (g[23:12] !== e.a) begin errors++; $display("FAIL %s dut_a got %h want %h", e.name, g[23:12], e.a); end
            if (g[11:0]  !== e.b) begin errors++; $display("FAIL %s dut_b got %h want %h", e.name, g[11:0], e.b); end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e; logic [23:0] g;
        step2("start_rem7", st(0,1,0,0,0,8'd0,2'd3), ob(1,1,0,1,7));
        step2("rst_cook",   rst_st(),                ZERO);
        step2("load1",      st(0,0,0,0,1,8'd1,2'd0), ob(0,0,0,0,1));
        step2("start_r1",   st(0,1,0,0,0,8'd0,2'd3), ob(1,1,0,1,1));
        step2("tick_bell",  st(0,0,0,1,0,8'd0,2'd0), ob(0,0,1,0,0));
        step2("bell_t1",    st(0,0,0,1,0,8'd0,2'd0), ob(0,0,1,0,0));
        step2("rst_bell",   rst_st(),                ZERO);
        step2("post_rst",   NOP,                     ZERO);
        while (sb.size() > 0) begin
            e = sb.pop_front(); g = obs_q.pop_front(); checks += 2;
            if (g[23:12] !== e.a) begin errors++; $display("FAIL %s dut_a got %h want %h", e.name, g[23:12], e.a); end
            if (g[11:0]  !== e.b) begin errors++; $display("FAIL %s dut_b got %h want %h", e.name, g[11:0], e.b); end
        end
    endtask

    task automatic test_bell_door();
        exp_t e; logic [23:0] g;
        step2("load1",     st(0,0,0,0,1,8'd1,2'd0), ob(0,0,0,0,1));
        step2("start_p2",  st(0,1,0,0,0,8'd0,2'd2), ob(1,1,0,1,1));
        step2("tick_bell", st(0,0,0,1,0,8'd0,2'd0), ob(0,0,1,0,0));
        step2("bell_door", st(1,0,0,1,0,8'd0,2'd0), ob(0,1,0,0,0));
        step2("close",     NOP,                     ZERO);
        while (sb.size() > 0) begin
            e = sb.pop_front(); g = obs_q.pop_front(); checks += 2;
            if (g[23:12] !== e.a) begin errors++; $display("FAIL %s dut_a got %h want %h", e.name, g[23:12], e.a); end
            if (g[11:0]  !== e.b) begin errors++; $display("FAIL %s dut_b got %h want %h", e.name, g[11:0], e.b); end
        end
    endtask

    initial begin
        test_reset();
        test_full_cook();
        test_pwm();
        test_pause_resume();
        test_idle_edges();
        test_reset_mid();
        test_bell_door();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
